pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage ARMv8 pipeline (IF/ID/EX/MEM/WB).
- Generates the EX-stage operand forwarding selects that drive the muxA/muxB operand muxes.
- Generates load-use stalls, taken-branch flushes and data-memory wait freezes.
- Holds the pipeline idle for a programmable number of cycles after reset so the instruction memory and register file settle before the first fetch.

Parameters:
INIT_CYCLES, 4, cycles spent in INIT after Reset deasserts before fetch starts; minimum 1.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  input  1  pipeline clock, rising edge
Reset  input  1  asynchronous, active-low reset
id_rn  input  5  Rn field of instruction in ID
id_rm  input  5  Rm field of instruction in ID
ex_rn  input  5  Rn of instruction in EX
ex_rm  input  5  Rm of instruction in EX
ex_rd  input  5  destination of instruction in EX
ex_memread  input  1  EX instruction is a load (LDUR)
mem_rd  input  5  destination in MEM
mem_regwrite  input  1  MEM instruction writes the register file
wb_rd  input  5  destination in WB
wb_regwrite  input  1  WB instruction writes the register file
br_taken  input  1  branch resolved taken in MEM
mem_req  input  1  MEM stage is accessing data memory
mem_ready  input  1  data memory completes the access this cycle
fwd_a  output  2  muxA select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
fwd_b  output  2  muxB select, same encoding
pc_write  output  1  PC register load enable
ifid_write  output  1  IF/ID register load enable
idex_bubble  output  1  load zero control into ID/EX
pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB
flush_ifid  output  1  clear IF/ID
flush_idex  output  1  clear ID/EX
flush_exmem  output  1  clear EX/MEM
state  output  2  00 INIT, 01 RUN, 10 MEM_WAIT

Behaviour:
- The state register and the INIT counter reset asynchronously when Reset is low. On reset: state=INIT, counter=0.
- All other outputs are Mealy functions of the state and the current inputs. There is no output register.
- While Reset is low, the outputs are: pc_write=0, ifid_write=0, idex_bubble=1, pipe_hold=0, all three flush outputs=1, fwd_a=fwd_b=00.
- INIT:
  - Outputs are identical to the reset outputs.
  - The counter increments each cycle.
  - When counter==INIT_CYCLES-1, the next state is RUN.
  - All other inputs are ignored in INIT.
- RUN, evaluated in priority order:
  1. mem_req=1 and mem_ready=0: pc_write=0, ifid_write=0, pipe_hold=1, no flush, no bubble. Next state is MEM_WAIT. A br_taken in the same cycle is ignored.
  2. br_taken=1: flush_ifid=1, flush_idex=1, flush_exmem=1, pc_write=1 (PC loads the branch target), ifid_write=1. Load-use detection is suppressed in this cycle. Lasts exactly one cycle.
  3. Load-use: ex_memread=1, ex_rd!=31, and (ex_rd==id_rn or ex_rd==id_rm). Response: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The following cycle sees the bubble in EX, so the condition clears.
  4. Otherwise: pc_write=1, ifid_write=1, and all other control outputs are 0.
- MEM_WAIT:
  - Holds the freeze outputs of RUN case 1 while mem_ready=0.
  - On the cycle mem_ready=1, the outputs equal RUN case 4 and the next state is RUN.
  - br_taken and load-use are not evaluated in MEM_WAIT.
- Forwarding (combinational, active in every state except INIT):
  - fwd_a=10 if mem_regwrite, mem_rd!=31 and mem_rd==ex_rn.
  - Else fwd_a=01 if wb_regwrite, wb_rd!=31 and wb_rd==ex_rn.
  - Else fwd_a=00.
  - fwd_b uses the same rules with ex_rm.
  - MEM has priority over WB when both match.
  - X31 (XZR) is never forwarded.
- Reset asserted mid-operation, including in MEM_WAIT, returns immediately to INIT with the reset outputs. INIT_CYCLES are re-counted after Reset deasserts.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, two additional output ports are present:
  - stall_cnt (CNT_W): counts cycles in RUN case 1, RUN case 3 and MEM_WAIT with mem_ready=0.
  - flush_cnt (CNT_W): counts br_taken flush cycles.
- Both counters reset asynchronously to 0, saturate at all-ones, and do not count in INIT.
- When not defined, both ports are still present and tied to 0, so the interface stays fixed. No counter logic is built.

Test Plan:
1. Reset low 3 cycles, then high with INIT_CYCLES=4 -> state=00 for 4 cycles with pc_write=0 and all flush outputs=1; state=01 and pc_write=1 on the 5th cycle.
2. ADD X1 in MEM (mem_rd=1, mem_regwrite=1), WB writes X1 (wb_rd=1), ex_rn=1, ex_rm=1 -> fwd_a=10, fwd_b=10. Then mem_rd=31 with wb_rd=1 -> fwd_a=01. Then wb_rd=31 -> fwd_a=00.
3. ex_memread=1, ex_rd=5, id_rm=5 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1. With ex_rd=31, no stall.
4. mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> state=10 for cycles 2-3, pipe_hold=1 for 3 cycles, RUN on the following cycle. A br_taken pulse during the wait produces no flush.
5. br_taken=1 with a simultaneous load-use match -> all three flush outputs=1, pc_write=1, idex_bubble=0 for one cycle.
6. Assert Reset during MEM_WAIT -> state=00 immediately (asynchronous), reset outputs driven. With HAZ_PERF_CNT_EN defined, stall_cnt=0 and flush_cnt=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding, stall, flush and post-reset sequencing for the 5-stage pipeline
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] XZR = 5'd31;

  // Settle counter only needs to reach INIT_CYCLES-1.
  localparam int             ICW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;

  logic mem_stall;
  logic load_use;

  // Hazard conditions shared by the next-state and output logic.
  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    load_use  = ex_memread & (ex_rd != XZR) & ((ex_rd == id_rn) | (ex_rd == id_rm));
  end

  // State register and settle counter; both clear asynchronously on Reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state: count out the settle period, then track outstanding data-memory waits.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control outputs: Mealy decode of state and current hazards, in RUN priority order.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          // Memory freeze outranks a branch; the branch re-resolves once MEM advances.
          pipe_hold = 1'b1;
        end else if (br_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end else begin
          pipe_hold = 1'b1;
        end
      end
      default: begin
        // INIT (and any unreachable encoding): pipeline idle and fully flushed.
        idex_bubble = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
      end
    endcase
  end

  // Operand forwarding selects; the younger MEM result wins and XZR is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (state_q != ST_INIT) begin
      if (mem_regwrite && (mem_rd != XZR) && (mem_rd == ex_rn)) begin
        fwd_a = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != XZR) && (wb_rd == ex_rn)) begin
        fwd_a = FWD_WB;
      end
      if (mem_regwrite && (mem_rd != XZR) && (mem_rd == ex_rm)) begin
        fwd_b = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != XZR) && (wb_rd == ex_rm)) begin
        fwd_b = FWD_WB;
      end
    end
  end

  assign state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic             stall_ev;
  logic             flush_ev;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counter events and saturating increments.
  always_comb begin
    stall_ev = ((state_q == ST_RUN) && (mem_stall || (!br_taken && load_use)))
             || ((state_q == ST_WAIT) && !mem_ready);
    flush_ev = (state_q == ST_RUN) && !mem_stall && br_taken;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_ev && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers; cleared asynchronously on Reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
